// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-channel types and arbiter-local definitions.
package axi_rd_arbiter_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;

  typedef logic [AXI_ID_WIDTH-1:0]   axi_id_t;
  typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
  typedef logic [7:0]                axi_len_t;
  typedef logic [2:0]                axi_size_t;
  typedef logic [1:0]                axi_burst_t;
  typedef logic [AXI_DATA_WIDTH-1:0] axi_data_t;
  typedef logic [1:0]                axi_resp_t;

  // Wide enough for MAX_OUTST up to 15.
  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] outst_cnt_t;

  typedef enum logic {
    AR_IDLE,
    AR_HOLD
  } ar_state_e;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;
  int unsigned   w_cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    w_idx   = r_ptr;
    w_cand  = 0;
    w_found = |req;
    for (int unsigned k = N; k > 0; k--) begin
      w_cand = (32'(r_ptr) + k - 1) % N;
      if (req[w_cand]) w_idx = IW'(w_cand);
    end
  end

  always_comb begin
    gnt = '0;
    if (w_found) gnt[w_idx] = 1'b1;
  end

  assign gnt_idx = w_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter: round-robin AR with ID tagging, ID-routed R demux,
// and a per-master outstanding-burst limit.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned N_MST     = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MST-1:0]     s_arvalid,
  output logic [N_MST-1:0]     s_arready,
  input  axi_id_t              s_arid    [N_MST],
  input  axi_addr_t            s_araddr  [N_MST],
  input  axi_len_t             s_arlen   [N_MST],
  input  axi_size_t            s_arsize  [N_MST],
  input  axi_burst_t           s_arburst [N_MST],
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output axi_id_t              m_arid,
  output axi_addr_t            m_araddr,
  output axi_len_t             m_arlen,
  output axi_size_t            m_arsize,
  output axi_burst_t           m_arburst,
  input  logic                 m_rvalid,
  input  axi_id_t              m_rid,
  input  axi_data_t            m_rdata,
  input  axi_resp_t            m_rresp,
  input  logic                 m_rlast,
  output logic                 m_rready,
  output logic [N_MST-1:0]     s_rvalid,
  output logic [N_MST-1:0]     s_rlast,
  output axi_id_t              s_rid,
  output axi_data_t            s_rdata,
  output axi_resp_t            s_rresp,
  input  logic [N_MST-1:0]     s_rready
);

  localparam int unsigned MIDX_W = $clog2(N_MST);

  ar_state_e          r_state;
  outst_cnt_t         r_cnt [N_MST];
  logic [N_MST-1:0]   w_elig;
  logic [N_MST-1:0]   w_gnt;
  logic [MIDX_W-1:0]  w_gidx;
  logic               w_grant;
  axi_id_t            w_tag_id;
  logic [MIDX_W-1:0]  w_owner;
  logic               w_owner_ok;
  logic               w_rdone;
  logic [N_MST-1:0]   w_inc;
  logic [N_MST-1:0]   w_dec;

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      w_elig[i] = s_arvalid[i] && (r_cnt[i] < CNT_W'(MAX_OUTST));
    end
  end

  assign w_grant = rst_n && (r_state == AR_IDLE) && (|w_elig);

  rr_arbiter #(
    .N (N_MST)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_elig),
    .advance (w_grant),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  assign s_arready = w_grant ? w_gnt : '0;

  always_comb begin
    w_tag_id = s_arid[w_gidx];
    w_tag_id[AXI_ID_WIDTH-1 -: MIDX_W] = w_gidx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= AR_IDLE;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      case (r_state)
        AR_IDLE: begin
          if (w_grant) begin
            r_state   <= AR_HOLD;
            m_arvalid <= 1'b1;
            m_arid    <= w_tag_id;
            m_araddr  <= s_araddr[w_gidx];
            m_arlen   <= s_arlen[w_gidx];
            m_arsize  <= s_arsize[w_gidx];
            m_arburst <= s_arburst[w_gidx];
          end
        end
        AR_HOLD: begin
          if (m_arready) begin
            r_state   <= AR_IDLE;
            m_arvalid <= 1'b0;
          end
        end
        default: begin
          r_state   <= AR_IDLE;
          m_arvalid <= 1'b0;
        end
      endcase
    end
  end

  assign w_owner = m_rid[AXI_ID_WIDTH-1 -: MIDX_W];

  // Tag values beyond N_MST-1 can only occur for non-power-of-two N_MST; route them nowhere.
  if ((2 ** MIDX_W) == N_MST) begin : g_owner_pow2
    assign w_owner_ok = 1'b1;
  end else begin : g_owner_npow2
    assign w_owner_ok = (w_owner <= MIDX_W'(N_MST - 1));
  end

  always_comb begin
    s_rvalid = '0;
    s_rlast  = '0;
    m_rready = 1'b0;
    if (w_owner_ok) begin
      s_rlast[w_owner] = m_rlast;
      if (rst_n) begin
        s_rvalid[w_owner] = m_rvalid;
        m_rready          = s_rready[w_owner];
      end
    end
  end

  always_comb begin
    s_rid = m_rid;
    s_rid[AXI_ID_WIDTH-1 -: MIDX_W] = '0;
  end

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;

  assign w_rdone = m_rvalid && m_rready && m_rlast;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      w_inc[i] = w_grant && w_gnt[i];
      w_dec[i] = w_rdone && w_owner_ok && (w_owner == MIDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (!rst_n) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (2 masters, outstanding limit 2).
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int NM  = 2;
  localparam int MO  = 2;
  localparam int IDW = AXI_ID_WIDTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_arvalid, s_arready;
  axi_id_t     s_arid    [2];
  axi_addr_t   s_araddr  [2];
  axi_len_t    s_arlen   [2];
  axi_size_t   s_arsize  [2];
  axi_burst_t  s_arburst [2];
  logic        m_arvalid, m_arready;
  axi_id_t     m_arid;
  axi_addr_t   m_araddr;
  axi_len_t    m_arlen;
  axi_size_t   m_arsize;
  axi_burst_t  m_arburst;
  logic        m_rvalid, m_rlast, m_rready;
  axi_id_t     m_rid;
  axi_data_t   m_rdata;
  axi_resp_t   m_rresp;
  logic [1:0]  s_rvalid, s_rlast, s_rready;
  axi_id_t     s_rid;
  axi_data_t   s_rdata;
  axi_resp_t   s_rresp;

  axi_rd_arbiter #(
    .N_MST     (NM),
    .MAX_OUTST (MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rready(m_rready),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending request flag, pointer, outstanding counts, held payload.
  bit         md_hold;
  int         md_rr;
  int         md_cnt [2];
  axi_id_t    md_id;
  axi_addr_t  md_addr;
  axi_len_t   md_len;
  axi_size_t  md_size;
  axi_burst_t md_burst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_hold = 0; md_rr = 0; md_cnt[0] = 0; md_cnt[1] = 0;
    md_id = '0; md_addr = '0; md_len = '0; md_size = '0; md_burst = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    int win, own, i;
    bit done;
    @(negedge clk);
    win = -1;
    if (rst_n && !md_hold) begin
      for (int j = 0; j < NM; j++) begin
        i = (md_rr + j) % NM;
        if (win < 0 && s_arvalid[i] && md_cnt[i] < MO) win = i;
      end
    end
    own = int'(m_rid) / (1 << (IDW - 1));
    chk("arvalid", 64'(m_arvalid), 64'(md_hold));
    chk("arid", 64'(m_arid), 64'(md_id));
    chk("araddr", 64'(m_araddr), 64'(md_addr));
    chk("arlen", 64'(m_arlen), 64'(md_len));
    chk("arsize_burst", 64'({m_arsize, m_arburst}), 64'({md_size, md_burst}));
    chk("arready", 64'(s_arready), (win < 0) ? 64'd0 : (64'd1 << win));
    chk("rvalid", 64'(s_rvalid), rst_n ? (64'(m_rvalid) << own) : 64'd0);
    chk("rlast", 64'(s_rlast), 64'(m_rlast) << own);
    chk("rready", 64'(m_rready), rst_n ? 64'(s_rready[own]) : 64'd0);
    chk("rid", 64'(s_rid), 64'(int'(m_rid) % (1 << (IDW - 1))));
    chk("rdata_resp", 64'({s_rdata, s_rresp}), 64'({m_rdata, m_rresp}));
    done = rst_n && m_rvalid && s_rready[own] && m_rlast;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < NM; k++) begin
        if (win == k && !(done && own == k)) md_cnt[k]++;
        else if (done && own == k && win != k && md_cnt[k] > 0) md_cnt[k]--;
      end
      if (win >= 0) begin
        md_hold  = 1;
        md_rr    = (win + 1) % NM;
        md_id    = axi_id_t'(int'(s_arid[win]) % (1 << (IDW - 1)) + win * (1 << (IDW - 1)));
        md_addr  = s_araddr[win];
        md_len   = s_arlen[win];
        md_size  = s_arsize[win];
        md_burst = s_arburst[win];
      end else if (md_hold && m_arready) begin
        md_hold = 0;
      end
    end
    #1;
  endtask

  task automatic rand_inputs();
    s_arvalid = 2'($urandom);
    for (int k = 0; k < NM; k++) begin
      s_arid[k] = axi_id_t'($urandom); s_araddr[k] = $urandom;
      s_arlen[k] = axi_len_t'($urandom); s_arsize[k] = axi_size_t'($urandom);
      s_arburst[k] = axi_burst_t'($urandom);
    end
    m_arready = 1'($urandom);
    m_rvalid  = 1'($urandom);
    m_rid     = axi_id_t'($urandom);
    m_rlast   = 1'($urandom);
    m_rdata   = $urandom;
    m_rresp   = axi_resp_t'($urandom);
    s_rready  = 2'($urandom);
    rst_n     = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; s_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rid = '0; m_rlast = 1'b0; m_rdata = '0; m_rresp = '0;
    s_rready = 2'b11;
    for (int k = 0; k < NM; k++) begin
      s_arid[k] = '0; s_araddr[k] = '0; s_arlen[k] = '0; s_arsize[k] = '0; s_arburst[k] = '0;
    end

    // Reset: requests and R traffic must be ignored.
    s_arvalid = 2'b11; m_rvalid = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1; s_arvalid = '0; m_rvalid = 1'b0;
    tick();

    // Single master burst.
    s_arvalid = 2'b01; s_arid[0] = 4'h3; s_araddr[0] = 32'h1000; s_arlen[0] = 8'd3;
    s_arsize[0] = 3'd2; s_arburst[0] = 2'd1; m_arready = 1'b1;
    tick();
    s_arvalid = '0;
    chk("single_arid_const", 64'(m_arid), 64'h3);
    chk("single_araddr_const", 64'(m_araddr), 64'h1000);
    tick();
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rid = 4'h3; m_rlast = (b == 3); m_rdata = $urandom;
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Fairness until both masters hit the limit.
    s_arvalid = 2'b11; s_arid[1] = 4'h5; s_araddr[1] = 32'h2000;
    repeat (9) tick();
    s_arvalid = '0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    m_rid = 4'h0; repeat (2) tick();
    m_rid = 4'h8; repeat (2) tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Outstanding limit on M0, M1 still served, M0 resumes after one rlast.
    s_arvalid = 2'b01;
    repeat (6) tick();
    s_arvalid = 2'b11;
    repeat (3) tick();
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 4'h1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (3) tick();
    s_arvalid = '0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // AR backpressure: payload held while upstream changes.
    s_arvalid = 2'b10; m_arready = 1'b0; s_arid[1] = 4'h6; s_araddr[1] = 32'hABCD_0000;
    tick();
    repeat (5) begin
      s_arid[1] = axi_id_t'($urandom); s_araddr[1] = $urandom;
      tick();
    end
    s_arvalid = '0; m_arready = 1'b1;
    repeat (2) tick();

    // R backpressure on M1.
    m_rvalid = 1'b1; m_rid = 4'h9; m_rlast = 1'b0; s_rready = 2'b01;
    repeat (2) tick();
    s_rready = 2'b11;
    tick();
    m_rvalid = 1'b0;

    // Reset during HOLD with counts (2,1).
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    s_arvalid = 2'b01; m_arready = 1'b1;
    repeat (4) tick();
    s_arvalid = 2'b10; m_arready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_arvalid_const", 64'(m_arvalid), 64'd0);
    s_arvalid = 2'b11; m_arready = 1'b1;
    tick();
    chk("rst_first_grant_m0", 64'(m_arid[IDW-1]), 64'd0);

    // Randomized traffic.
    repeat (400) begin
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
